// File: rtl/mm_pkg.sv
// Shared constants and helpers for the matrix-multiply operand/result paths.
// Element k of a bus word occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
package mm_pkg;

    localparam int unsigned ARRAY_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF  = 16;
    localparam int unsigned BUS_WIDTH_DEF   = 256;

    function automatic int unsigned beats_per_word(input int unsigned bus_width,
                                                   input int unsigned data_width,
                                                   input int unsigned array_width);
        return bus_width / (data_width * array_width);
    endfunction

    // Element number carried by a given row on a given beat of a word.
    function automatic int unsigned elem_index(input int unsigned beat,
                                               input int unsigned row,
                                               input int unsigned array_width);
        return beat * array_width + row;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length valid/data delay line with a common shift enable.
// On an invalid input the first stage keeps its previous data.
module skew_delay_line #(
    parameter int unsigned LENGTH = 1,
    parameter int unsigned WIDTH  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             any_valid
);

    logic [LENGTH-1:0]            valid_q;
    logic [LENGTH-1:0][WIDTH-1:0] data_q;
    logic [LENGTH:0]              valid_sh;
    logic [LENGTH:0][WIDTH-1:0]   data_sh;
    logic [WIDTH-1:0]             first_data;

    // Shift vectors carry one extra slot so LENGTH == 1 needs no special case.
    assign first_data = in_valid ? in_data : data_q[0];
    assign valid_sh   = {valid_q, in_valid};
    assign data_sh    = {data_q, first_data};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (shift_en) begin
            valid_q <= valid_sh[LENGTH-1:0];
            data_q  <= data_sh[LENGTH-1:0];
        end
    end

    assign out_valid = valid_q[LENGTH-1];
    assign out_data  = data_q[LENGTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/operand_feed_lane.sv
// Buffers bus-side operand words and feeds them, one element per row per beat,
// into the systolic array rows with row r lagging row 0 by r cycles.
module operand_feed_lane
    import mm_pkg::*;
#(
    parameter int unsigned ARRAY_WIDTH = ARRAY_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic                  valid_i,
    output logic                  accepted_o,
    input  logic                  array_ready_i,
    output logic [DATA_WIDTH-1:0] array_data_o [ARRAY_WIDTH],
    output logic                  array_valid_o [ARRAY_WIDTH],
    output logic                  busy_o
);

    localparam int unsigned BEATS = beats_per_word(BUS_WIDTH, DATA_WIDTH, ARRAY_WIDTH);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [BCW-1:0] BEAT_ONE  = 1;
    localparam logic [AW:0]    PTR_ONE   = 1;

    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          w_ptr;
    logic [AW:0]          r_ptr;
    logic [BCW-1:0]       beat_cnt;
    logic                 full;
    logic                 empty;
    logic                 advance;
    logic [ARRAY_WIDTH-1:0] row_busy;

    // Beat-major view of the head word: element beat*ARRAY_WIDTH + row.
    logic [BEATS-1:0][ARRAY_WIDTH-1:0][DATA_WIDTH-1:0] head_beats;

    assign empty      = (w_ptr == r_ptr);
    assign full       = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
    assign accepted_o = reset_n & valid_i & ~full;
    assign advance    = array_ready_i & ~empty;
    assign head_beats = mem[r_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (accepted_o) begin
            mem[w_ptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            beat_cnt <= '0;
        end else begin
            if (accepted_o) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (advance) begin
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    r_ptr    <= r_ptr + PTR_ONE;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_ONE;
                end
            end
        end
    end

    for (genvar r = 0; r < ARRAY_WIDTH; r++) begin : g_row
        skew_delay_line #(
            .LENGTH (r + 1),
            .WIDTH  (DATA_WIDTH)
        ) u_skew (
            .clk       (clk),
            .reset_n   (reset_n),
            .shift_en  (array_ready_i),
            .in_valid  (advance),
            .in_data   (head_beats[beat_cnt][r]),
            .out_valid (array_valid_o[r]),
            .out_data  (array_data_o[r]),
            .any_valid (row_busy[r])
        );
    end

    assign busy_o = ~empty | (|row_busy);

endmodule

// File: tb/tb_operand_feed_lane.sv
// Self-checking bench for operand_feed_lane: directed corner cases, a vector
// table and a randomized run against a transaction-level reference model.
module tb_operand_feed_lane;
    import mm_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned BW    = 256;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BEATS = beats_per_word(BW, DW, AW);
    localparam int unsigned NE    = BW / DW;

    typedef logic [BW-1:0] word_t;
    typedef struct packed {
        logic                 v;
        logic [AW-1:0][DW-1:0] d;
    } tok_t;
    typedef struct {
        logic          v;
        logic          exp_acc;
        logic          exp_busy;
        logic          exp_v3;
        logic [DW-1:0] exp_d3;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    word_t         data = '0;
    logic          valid = 1'b0;
    logic          array_ready = 1'b1;
    logic          accepted;
    logic [DW-1:0] row_data [AW];
    logic          row_valid [AW];
    logic          busy;

    always #5 clk = ~clk;

    operand_feed_lane #(
        .ARRAY_WIDTH (AW),
        .DATA_WIDTH  (DW),
        .BUS_WIDTH   (BW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_i        (data),
        .valid_i       (valid),
        .accepted_o    (accepted),
        .array_ready_i (array_ready),
        .array_data_o  (row_data),
        .array_valid_o (row_valid),
        .busy_o        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered words, beat position of the head word,
    // and the last AW row-0 issue tokens (row r shows the token issued r shifts ago).
    word_t                 mq[$];
    tok_t                  hist[$];
    int unsigned           mb = 0;
    logic [AW-1:0][DW-1:0] held = '0;
    logic                  acc_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input word_t w, input int unsigned k);
        logic [NE-1:0][DW-1:0] v;
        v = w;
        return v[k[$clog2(NE)-1:0]];
    endfunction

    function automatic word_t mk_word(input int unsigned base);
        word_t w = '0;
        for (int unsigned j = 0; j < NE; j++) w = {w[BW-DW-1:0], DW'(base + NE - 1 - j)};
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w = '0;
        for (int unsigned j = 0; j < BW / 32; j++) w = {w[BW-33:0], 32'($urandom())};
        return w;
    endfunction

    task automatic model_edge(input logic v, input word_t d, input logic rdy,
                              input logic rst, input logic acc);
        if (!rst) begin
            mq.delete();
            hist.delete();
            mb   = 0;
            held = '0;
        end else begin
            if (rdy) begin
                tok_t t;
                t.v = 1'b0;
                if (mq.size() != 0) begin
                    t.v = 1'b1;
                    for (int r = 0; r < AW; r++) held[r] = elem(mq[0], elem_index(mb, r, AW));
                    mb++;
                    if (mb == BEATS) begin
                        mb = 0;
                        void'(mq.pop_front());
                    end
                end
                t.d = held;
                hist.push_back(t);
                if (hist.size() > AW) void'(hist.pop_front());
            end
            if (acc && v) mq.push_back(d);
        end
    endtask

    task automatic check_outputs();
        logic bexp;
        bexp = (mq.size() != 0);
        foreach (hist[i]) if (hist[i].v) bexp = 1'b1;
        for (int r = 0; r < AW; r++) begin
            int            idx;
            logic          ev;
            logic [DW-1:0] ed;
            idx = hist.size() - 1 - r;
            ev  = 1'b0;
            ed  = '0;
            if (idx >= 0) begin
                ev = hist[idx].v;
                ed = hist[idx].d[r];
            end
            chk($sformatf("row%0d_valid", r), 64'(row_valid[r]), 64'(ev));
            chk($sformatf("row%0d_data", r), 64'(row_data[r]), 64'(ed));
        end
        chk("busy", 64'(busy), 64'(bexp));
    endtask

    // One clock cycle: drive at the falling edge, check the handshake, clock,
    // then check the registered outputs just after the rising edge.
    task automatic step(input logic v, input word_t d, input logic rdy, input logic rst);
        logic exp_acc;
        valid       = v;
        data        = d;
        array_ready = rdy;
        reset_n     = rst;
        #1;
        exp_acc = rst && v && (mq.size() < DEPTH);
        chk("accepted", 64'(accepted), 64'(exp_acc));
        acc_seen = accepted;
        @(posedge clk);
        model_edge(v, d, rdy, rst, exp_acc);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic single_word(input int unsigned base, input string tag);
        step(1'b1, mk_word(base), 1'b1, 1'b1);
        chk({tag, "_accept"}, 64'(acc_seen), 64'(1));
        for (int n = 0; n < 10; n++) begin
            if (n > 0) step(1'b0, '0, 1'b1, 1'b1);
            for (int r = 0; r < AW; r++) begin
                logic ev;
                ev = (n >= 1 + r) && (n <= 4 + r);
                chk($sformatf("%s_r%0d_v_n%0d", tag, r, n), 64'(row_valid[r]), 64'(ev));
                if (ev) chk($sformatf("%s_r%0d_d_n%0d", tag, r, n), 64'(row_data[r]),
                            64'(base + r + 4 * (n - 1 - r)));
            end
            chk($sformatf("%s_busy_n%0d", tag, n), 64'(busy), 64'(n < 8));
        end
    endtask

    initial begin
        vec_t  tbl [10];
        word_t w2 [8];
        word_t w4 [5];
        word_t w;
        int    acc_cyc[$];
        int    exp_cyc [8];
        int    sent;
        int    first, last, cnt;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1003};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1007};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h100B};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h100F};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h100F};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h100F};
        exp_cyc = '{0, 1, 2, 3, 5, 9, 13, 17};

        @(negedge clk);
        pulse_reset();
        step(1'b1, mk_word(16'h0F00), 1'b1, 1'b0);
        chk("reset_accept_forced", 64'(acc_seen), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        for (int r = 0; r < AW; r++) begin
            chk($sformatf("reset_r%0d_v", r), 64'(row_valid[r]), 64'(0));
            chk($sformatf("reset_r%0d_d", r), 64'(row_data[r]), 64'(0));
        end

        // Single word, elements 0..15.
        single_word(0, "single");

        // Back-to-back words with valid held high.
        pulse_reset();
        for (int i = 0; i < 8; i++) w2[i] = rand_word();
        sent = 0; first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step(sent < 8, (sent < 8) ? w2[sent] : '0, 1'b1, 1'b1);
            if (acc_seen) begin
                acc_cyc.push_back(c);
                sent++;
            end
            if (row_valid[0]) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        chk("b2b_accept_count", 64'(acc_cyc.size()), 64'(8));
        for (int i = 0; i < 8 && i < acc_cyc.size(); i++)
            chk($sformatf("b2b_accept_cycle%0d", i), 64'(acc_cyc[i]), 64'(exp_cyc[i]));
        chk("b2b_row0_count", 64'(cnt), 64'(32));
        chk("b2b_row0_first", 64'(first), 64'(1));
        chk("b2b_row0_last", 64'(last), 64'(32));

        // Stall for three cycles while beat 2 is next to issue.
        pulse_reset();
        step(1'b1, mk_word(16'h0300), 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            chk($sformatf("stall_r0_v_%0d", s), 64'(row_valid[0]), 64'(1));
            chk($sformatf("stall_r0_d_%0d", s), 64'(row_data[0]), 64'(16'h0304));
            chk($sformatf("stall_r1_d_%0d", s), 64'(row_data[1]), 64'(16'h0301));
            chk($sformatf("stall_r2_v_%0d", s), 64'(row_valid[2]), 64'(0));
        end
        step(1'b0, '0, 1'b1, 1'b1);
        chk("release_r0_d", 64'(row_data[0]), 64'(16'h0308));
        chk("release_r1_d", 64'(row_data[1]), 64'(16'h0305));
        chk("release_r2_v", 64'(row_valid[2]), 64'(1));
        chk("release_r2_d", 64'(row_data[2]), 64'(16'h0302));
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);

        // FIFO full with the array stalled, then released.
        pulse_reset();
        for (int i = 0; i < 5; i++) w4[i] = mk_word(32'h4000 + 32'h10 * i);
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            step(sent < 5, (sent < 5) ? w4[sent] : '0, c >= 7, 1'b1);
            chk($sformatf("full_accept_c%0d", c), 64'(acc_seen), 64'((c < 4) || (c == 11)));
            if (acc_seen) sent++;
        end
        for (int i = 0; i < 24; i++) step(1'b0, '0, 1'b1, 1'b1);

        // Reset with words in flight.
        pulse_reset();
        step(1'b1, rand_word(), 1'b1, 1'b1);
        step(1'b1, rand_word(), 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, rand_word(), 1'b1, 1'b0);
        chk("midrst_accept", 64'(acc_seen), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        for (int r = 0; r < AW; r++) begin
            chk($sformatf("midrst_r%0d_v", r), 64'(row_valid[r]), 64'(0));
            chk($sformatf("midrst_r%0d_d", r), 64'(row_data[r]), 64'(0));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            chk($sformatf("midrst_idle_busy%0d", i), 64'(busy), 64'(0));
        end
        single_word(32'hA500, "after_rst");

        // Element mapping onto row 3, table driven.
        pulse_reset();
        w = mk_word(32'h1000);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, w, 1'b1, 1'b1);
            chk($sformatf("tbl%0d_accept", i), 64'(acc_seen), 64'(tbl[i].exp_acc));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_r3_v", i), 64'(row_valid[3]), 64'(tbl[i].exp_v3));
            chk($sformatf("tbl%0d_r3_d", i), 64'(row_data[3]), 64'(tbl[i].exp_d3));
        end

        // Randomized traffic, stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 299) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
